// File: rtl/axis_fifo_v3_if.sv
// AXI4-Stream beat bundle shared by the producer and consumer sides of axis_fifo_v3.
interface axis_fifo_v3_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH/8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );
endinterface

// File: rtl/axis_fifo_v3.sv
// Single-clock AXI4-Stream FIFO with first-word fall-through, optional store-and-forward
// packet mode (cut-through fallback for oversize packets) and fill/packet-count status.
module axis_fifo_v3 #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH/8,
  parameter int unsigned DEPTH       = 16,
  parameter bit          PACKET_MODE = 1'b0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_fifo_v3_if.slave          s_axis,
  axis_fifo_v3_if.master         m_axis,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [$clog2(DEPTH):0] pkt_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic {
    ST_HEAD,
    ST_DRAIN
  } drain_state_e;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          ready_en;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          pkt_inc;
  logic          pkt_dec;
  logic          m_valid;
  drain_state_e  state;
  drain_state_e  state_nxt;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  // ready_en keeps tready low during reset and for the release edge itself
  assign s_axis.tready = ready_en & ~full;
  assign wr_en         = s_axis.tvalid & s_axis.tready;
  assign rd_en         = m_valid & m_axis.tready;

  assign head          = mem[rd_ptr[AW-1:0]];
  assign m_axis.tdata  = head[EW-1 -: DATA_WIDTH];
  assign m_axis.tkeep  = head[KEEP_WIDTH:1];
  assign m_axis.tlast  = head[0];
  assign m_axis.tvalid = m_valid;

  assign pkt_inc = wr_en & s_axis.tlast;
  assign pkt_dec = rd_en & m_axis.tlast & (pkt_count != '0);

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_count  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (wr_en && !rd_en) begin
        fill_level <= fill_level + ONE;
      end else if (rd_en && !wr_en) begin
        fill_level <= fill_level - ONE;
      end
      if (pkt_inc && !pkt_dec) begin
        pkt_count <= pkt_count + ONE;
      end else if (pkt_dec && !pkt_inc) begin
        pkt_count <= pkt_count - ONE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_HEAD;
    end else begin
      state <= state_nxt;
    end
  end

  // ST_DRAIN: a packet has begun leaving, so its remaining beats go out as stored
  always_comb begin
    state_nxt = state;
    m_valid   = ~empty;
    if (PACKET_MODE) begin
      m_valid = ~empty & ((pkt_count != '0) | full | (state == ST_DRAIN));
      if (rd_en) begin
        state_nxt = m_axis.tlast ? ST_HEAD : ST_DRAIN;
      end
    end
  end

endmodule
